// File: rtl/uart_bus_master_if.sv
// uart_bus_master_if: RX/TX byte-stream handshakes and MMIO bus signals of the bridge
interface uart_bus_master_if #(
  parameter int ADDR_W = 26
);
  logic [7:0]        i_rx_data;
  logic              i_rx_valid;
  logic              o_rx_ready;
  logic [7:0]        o_tx_data;
  logic              o_tx_valid;
  logic              i_tx_ready;
  logic [ADDR_W-1:0] o_addr;
  logic [31:0]       o_data;
  logic [3:0]        o_byte_we;
  logic              o_read_en;
  logic [31:0]       i_data;
  logic              o_busy;

  modport master (
    input  i_rx_data, i_rx_valid, i_tx_ready, i_data,
    output o_rx_ready, o_tx_data, o_tx_valid, o_addr, o_data, o_byte_we, o_read_en, o_busy
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_tx_ready, i_data,
    input  o_rx_ready, o_tx_data, o_tx_valid, o_addr, o_data, o_byte_we, o_read_en, o_busy
  );
endinterface

// File: rtl/uart_bus_master.sv
// uart_bus_master: turns UART command bytes into single 32-bit MMIO reads/writes and streams back ack/read data
module uart_bus_master #(
  parameter int ADDR_W         = 26,
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input logic               i_clk,
  input logic               i_rst_n,
  uart_bus_master_if.master bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_BUS_WR, S_BUS_RD, S_WAIT_RD, S_RESP
  } state_t;

  state_t            r_state;
  logic              r_is_wr;
  logic [1:0]        r_cnt;
  logic [31:0]       r_addr;
  logic [31:0]       r_data;
  logic [23:0]       r_resp;
  logic [1:0]        r_left;
  logic [TW-1:0]     r_tmo;
  logic [1:0]        r_lat;
  logic              r_rx_ready;
  logic              r_tx_valid;
  logic [7:0]        r_tx_data;
  logic [ADDR_W-1:0] r_addr_out;
  logic [31:0]       r_data_out;
  logic [3:0]        r_byte_we;
  logic              r_read_en;

  logic        w_rx_fire;
  logic        w_tx_fire;
  logic        w_tmo_hit;
  logic        w_lat_hit;
  logic [31:0] w_addr_next;
  logic [31:0] w_data_next;
  logic        w_unused;

  assign w_rx_fire   = bus.i_rx_valid && r_rx_ready;
  assign w_tx_fire   = r_tx_valid && bus.i_tx_ready;
  assign w_tmo_hit   = r_tmo == TW'(TIMEOUT_CYCLES - 1);
  assign w_lat_hit   = r_lat == 2'(READ_LATENCY - 1);
  assign w_addr_next = {bus.i_rx_data, r_addr[31:8]};
  assign w_data_next = {bus.i_rx_data, r_data[31:8]};
  assign w_unused    = &{1'b0, r_addr};

  assign bus.o_rx_ready = r_rx_ready;
  assign bus.o_tx_valid = r_tx_valid;
  assign bus.o_tx_data  = r_tx_data;
  assign bus.o_addr     = r_addr_out;
  assign bus.o_data     = r_data_out;
  assign bus.o_byte_we  = r_byte_we;
  assign bus.o_read_en  = r_read_en;
  assign bus.o_busy     = r_state != S_IDLE;

  // Command FSM: collects opcode/address/data LSB first, issues one bus strobe, then drains the response bytes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_is_wr    <= 1'b0;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_resp     <= '0;
      r_left     <= '0;
      r_tmo      <= '0;
      r_lat      <= '0;
      r_rx_ready <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_addr_out <= '0;
      r_data_out <= '0;
      r_byte_we  <= '0;
      r_read_en  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rx_ready <= 1'b1;
          r_cnt      <= '0;
          r_tmo      <= '0;
          if (w_rx_fire) begin
            if (bus.i_rx_data == OP_WR || bus.i_rx_data == OP_RD) begin
              r_is_wr <= bus.i_rx_data == OP_WR;
              r_state <= S_ADDR;
            end else begin
              r_rx_ready <= 1'b0;
              r_tx_valid <= 1'b1;
              r_tx_data  <= RSP_ERR;
              r_left     <= '0;
              r_state    <= S_RESP;
            end
          end
        end
        S_ADDR, S_DATA: begin
          if (w_rx_fire) begin
            r_tmo <= '0;
            r_cnt <= r_cnt + 1'b1;
            if (r_state == S_ADDR) r_addr <= w_addr_next;
            else r_data <= w_data_next;
            if (r_cnt == 2'd3 && r_state == S_DATA) begin
              r_rx_ready <= 1'b0;
              r_addr_out <= r_addr[ADDR_W+1:2];
              r_data_out <= w_data_next;
              r_byte_we  <= 4'hF;
              r_state    <= S_BUS_WR;
            end else if (r_cnt == 2'd3 && !r_is_wr) begin
              r_rx_ready <= 1'b0;
              r_addr_out <= w_addr_next[ADDR_W+1:2];
              r_read_en  <= 1'b1;
              r_state    <= S_BUS_RD;
            end else if (r_cnt == 2'd3) begin
              r_state <= S_DATA;
            end
          end else if (w_tmo_hit) begin
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_BUS_WR: begin
          r_byte_we  <= '0;
          r_tx_valid <= 1'b1;
          r_tx_data  <= RSP_ACK;
          r_left     <= '0;
          r_state    <= S_RESP;
        end
        S_BUS_RD: begin
          r_read_en <= 1'b0;
          r_lat     <= '0;
          r_state   <= S_WAIT_RD;
        end
        S_WAIT_RD: begin
          if (w_lat_hit) begin
            r_tx_data  <= bus.i_data[7:0];
            r_resp     <= bus.i_data[31:8];
            r_left     <= 2'd3;
            r_tx_valid <= 1'b1;
            r_state    <= S_RESP;
          end else begin
            r_lat <= r_lat + 1'b1;
          end
        end
        S_RESP: begin
          if (w_tx_fire && r_left == '0) begin
            r_tx_valid <= 1'b0;
            r_rx_ready <= 1'b1;
            r_state    <= S_IDLE;
          end else if (w_tx_fire) begin
            r_tx_data <= r_resp[7:0];
            r_resp    <= {8'h00, r_resp[23:8]};
            r_left    <= r_left - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_bus_master.sv
// tb_uart_bus_master: randomized command streams checked against a byte-level protocol and memory model
module tb_uart_bus_master;
  localparam int AW  = 26;
  localparam int LAT = 2;
  localparam int TMO = 16;
  localparam int EW  = AW + 37;
  localparam int OW  = AW + 48;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  uart_bus_master_if #(.ADDR_W(AW)) bus();

  uart_bus_master #(.ADDR_W(AW), .READ_LATENCY(LAT), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int conflicts   = 0;
  bit hold_ready  = 1'b0;
  bit rand_ready  = 1'b0;
  int rd_cnt      = 0;
  logic [AW-1:0] rd_addr;
  logic [31:0]   mem [logic [AW-1:0]];
  logic [EW-1:0] ev_q [$];
  logic [7:0]    tx_q [$];

  function automatic logic [31:0] mem_val(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : (32'hC0DE0000 ^ 32'(a));
  endfunction

  function automatic logic [31:0] tx_word(input int base);
    logic [31:0] v;
    v = 'x;
    for (int i = 0; i < 4; i++) if (base + i < tx_q.size()) v[8*i +: 8] = tx_q[base + i];
    return v;
  endfunction

  function automatic logic [EW-1:0] ev_at(input int i);
    return i < ev_q.size() ? ev_q[i] : {EW{1'bx}};
  endfunction

  // Peripheral model: returns data exactly READ_LATENCY cycles after the strobe, junk on every other cycle
  always @(negedge clk) begin
    if (bus.o_read_en) begin
      rd_cnt      = LAT;
      rd_addr     = bus.o_addr;
      bus.i_data  = $urandom;
    end else if (rd_cnt > 0) begin
      rd_cnt--;
      bus.i_data = (rd_cnt == 0) ? mem_val(rd_addr) : $urandom;
    end else begin
      bus.i_data = $urandom;
    end
  end

  // Monitor: logs bus strobes and accepted response bytes
  always @(negedge clk) begin
    if (bus.o_read_en && bus.o_byte_we != 4'h0) conflicts++;
    if (bus.o_byte_we != 4'h0) ev_q.push_back({1'b0, bus.o_byte_we, bus.o_addr, bus.o_data});
    else if (bus.o_read_en) ev_q.push_back({1'b1, 4'h0, bus.o_addr, 32'h0});
    if (bus.o_tx_valid && bus.i_tx_ready) tx_q.push_back(bus.o_tx_data);
  end

  // TX FIFO model: always ready, randomly stalling, or held off
  always @(posedge clk) begin
    #1;
    bus.i_tx_ready = hold_ready ? 1'b0 : rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got running exp finished");
    $fatal(1);
  end

  task automatic gap(input int gmax);
    int g;
    g = $urandom_range(0, gmax);
    if (g > 0) begin
      repeat (g) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    @(negedge clk);
    while (!bus.o_rx_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      miscompares++;
      $display("FAIL rx_accept byte %02h: ready never seen, got 0 exp 1", b);
    end
    @(posedge clk);
    #1;
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d, input int gmax);
    send_byte(op);
    if (op == 8'h57 || op == 8'h52)
      for (int i = 0; i < 4; i++) begin
        gap(gmax);
        send_byte(a[8*i +: 8]);
      end
    if (op == 8'h57)
      for (int i = 0; i < 4; i++) begin
        gap(gmax);
        send_byte(d[8*i +: 8]);
      end
  endtask

  task automatic wait_done(input int n);
    int t;
    t = 0;
    while ((tx_q.size() < n || bus.o_busy) && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) begin
      miscompares++;
      $display("FAIL wait_done: got %0d bytes busy=%0b exp %0d bytes idle", tx_q.size(), bus.o_busy, n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [OW-1:0] outs;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    outs = {bus.o_rx_ready, bus.o_tx_valid, bus.o_tx_data, bus.o_addr, bus.o_data, bus.o_byte_we, bus.o_read_en, bus.o_busy};
    vectors++;
    if (outs !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got %h exp 0", outs);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    vectors++;
    if (bus.o_rx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready_before_edge got %b exp 0", bus.o_rx_ready);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus.o_rx_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready_after_edge got ready=%b busy=%b exp 1 0", bus.o_rx_ready, bus.o_busy);
    end
  endtask

  task automatic test_write();
    ev_q.delete();
    tx_q.delete();
    send_cmd(8'h57, 32'h0000_0010, 32'hDEADBEEF, 0);
    mem[AW'(4)] = 32'hDEADBEEF;
    wait_done(1);
    vectors++;
    if (ev_q.size() !== 1 || ev_at(0) !== {1'b0, 4'hF, AW'(4), 32'hDEADBEEF}) begin
      miscompares++;
      $display("FAIL write_strobe got n=%0d %h exp n=1 %h", ev_q.size(), ev_at(0), {1'b0, 4'hF, AW'(4), 32'hDEADBEEF});
    end
    vectors++;
    if (tx_q.size() !== 1 || tx_q[0] !== 8'h4B) begin
      miscompares++;
      $display("FAIL write_ack got n=%0d %h exp n=1 4b", tx_q.size(), tx_word(0));
    end
  endtask

  task automatic test_read();
    ev_q.delete();
    tx_q.delete();
    mem[AW'(1)] = 32'h12345678;
    send_cmd(8'h52, 32'h0000_0004, 32'h0, 0);
    wait_done(4);
    vectors++;
    if (ev_q.size() !== 1 || ev_at(0) !== {1'b1, 4'h0, AW'(1), 32'h0}) begin
      miscompares++;
      $display("FAIL read_strobe got n=%0d %h exp n=1 %h", ev_q.size(), ev_at(0), {1'b1, 4'h0, AW'(1), 32'h0});
    end
    vectors++;
    if (tx_q.size() !== 4 || tx_word(0) !== 32'h12345678) begin
      miscompares++;
      $display("FAIL read_data got n=%0d %h exp n=4 12345678", tx_q.size(), tx_word(0));
    end
  endtask

  task automatic test_bad_opcode();
    logic [31:0] d;
    d = $urandom;
    ev_q.delete();
    tx_q.delete();
    send_cmd(8'h41, 32'h0, 32'h0, 0);
    wait_done(1);
    vectors++;
    if (ev_q.size() !== 0 || tx_q.size() !== 1 || tx_q[0] !== 8'h3F) begin
      miscompares++;
      $display("FAIL bad_opcode got strobes=%0d n=%0d %h exp 0 1 3f", ev_q.size(), tx_q.size(), tx_word(0));
    end
    ev_q.delete();
    tx_q.delete();
    send_cmd(8'h57, 32'h0000_0020, d, 0);
    mem[AW'(8)] = d;
    wait_done(1);
    vectors++;
    if (ev_q.size() !== 1 || ev_at(0) !== {1'b0, 4'hF, AW'(8), d} || tx_q.size() !== 1 || tx_q[0] !== 8'h4B) begin
      miscompares++;
      $display("FAIL write_after_bad got %h n=%0d exp %h ack", ev_at(0), tx_q.size(), {1'b0, 4'hF, AW'(8), d});
    end
  endtask

  task automatic test_backpressure();
    int t;
    int bad;
    t = 0;
    bad = 0;
    ev_q.delete();
    tx_q.delete();
    mem[AW'(1)] = 32'h12345678;
    hold_ready = 1'b1;
    send_cmd(8'h52, 32'h0000_0004, 32'h0, 1);
    while (!bus.o_tx_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.o_tx_valid !== 1'b1 || bus.o_tx_data !== 8'h78 || bus.o_rx_ready !== 1'b0) bad++;
    end
    vectors++;
    if (bad !== 0 || tx_q.size() !== 0) begin
      miscompares++;
      $display("FAIL stall_hold got %0d unstable cycles, %0d bytes exp 0 0 (data %h exp 78)", bad, tx_q.size(), bus.o_tx_data);
    end
    @(posedge clk);
    #1 hold_ready = 1'b0;
    wait_done(4);
    vectors++;
    if (tx_q.size() !== 4 || tx_word(0) !== 32'h12345678) begin
      miscompares++;
      $display("FAIL stall_release got n=%0d %h exp n=4 12345678", tx_q.size(), tx_word(0));
    end
  endtask

  task automatic test_timeout();
    ev_q.delete();
    tx_q.delete();
    send_byte(8'h57);
    send_byte(8'h10);
    repeat (TMO - 1) @(posedge clk);
    #1;
    vectors++;
    if (bus.o_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_early got busy=%b exp 1", bus.o_busy);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus.o_busy !== 1'b0 || bus.o_rx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_abort got busy=%b ready=%b exp 0 1", bus.o_busy, bus.o_rx_ready);
    end
    send_cmd(8'h52, 32'h0, 32'h0, 0);
    wait_done(4);
    vectors++;
    if (ev_q.size() !== 1 || ev_at(0) !== {1'b1, 4'h0, AW'(0), 32'h0} || tx_q.size() !== 4 || tx_word(0) !== mem_val(AW'(0))) begin
      miscompares++;
      $display("FAIL timeout_next_read got n=%0d %h data %h exp read addr 0 data %h", ev_q.size(), ev_at(0), tx_word(0), mem_val(AW'(0)));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    d = $urandom;
    ev_q.delete();
    tx_q.delete();
    rand_ready = 1'b1;
    send_cmd(8'h57, 32'h0000_0014, d, 0);
    mem[AW'(5)] = d;
    send_cmd(8'h52, 32'h0000_0014, 32'h0, 0);
    wait_done(5);
    vectors++;
    if (ev_q.size() !== 2 || ev_at(0) !== {1'b0, 4'hF, AW'(5), d} || ev_at(1) !== {1'b1, 4'h0, AW'(5), 32'h0}) begin
      miscompares++;
      $display("FAIL b2b_strobes got n=%0d %h %h exp write+read of word 5 data %h", ev_q.size(), ev_at(0), ev_at(1), d);
    end
    vectors++;
    if (tx_q.size() !== 5 || tx_q[0] !== 8'h4B || tx_word(1) !== d) begin
      miscompares++;
      $display("FAIL b2b_resp got n=%0d %h exp n=5 4b then %h", tx_q.size(), tx_word(1), d);
    end
  endtask

  task automatic test_random();
    rand_ready = 1'b1;
    for (int n = 0; n < 24; n++) begin
      int r;
      int nb;
      int ne;
      logic [7:0]    op;
      logic [31:0]   a;
      logic [31:0]   d;
      logic [31:0]   xr;
      logic [AW-1:0] w;
      logic [EW-1:0] xe;
      r  = $urandom_range(0, 9);
      op = r < 4 ? 8'h57 : r < 8 ? 8'h52 : 8'($urandom_range(0, 8'h50));
      a  = ($urandom & 32'hF000_0003) | (32'($urandom_range(0, 7)) << 2);
      d  = $urandom;
      w  = AW'(a >> 2);
      if (op == 8'h57) begin
        xe = {1'b0, 4'hF, w, d};
        xr = 32'h4B;
        nb = 1;
        ne = 1;
      end else if (op == 8'h52) begin
        xe = {1'b1, 4'h0, w, 32'h0};
        xr = mem_val(w);
        nb = 4;
        ne = 1;
      end else begin
        xe = {EW{1'bx}};
        xr = 32'h3F;
        nb = 1;
        ne = 0;
      end
      ev_q.delete();
      tx_q.delete();
      send_cmd(op, a, d, 4);
      if (op == 8'h57) mem[w] = d;
      wait_done(nb);
      vectors++;
      if (ev_q.size() !== ne || (ne == 1 && ev_at(0) !== xe)) begin
        miscompares++;
        $display("FAIL rand_strobe[%0d] op %h got n=%0d %h exp n=%0d %h", n, op, ev_q.size(), ev_at(0), ne, xe);
      end
      vectors++;
      if (tx_q.size() !== nb || (nb == 4 ? tx_word(0) !== xr : tx_q[0] !== xr[7:0])) begin
        miscompares++;
        $display("FAIL rand_resp[%0d] op %h got n=%0d %h exp n=%0d %h", n, op, tx_q.size(), tx_word(0), nb, xr);
      end
    end
    rand_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [OW-1:0] outs;
    ev_q.delete();
    tx_q.delete();
    send_cmd(8'h52, 32'h0000_000C, 32'h0, 0);
    @(posedge clk);
    #1;
    vectors++;
    if (bus.o_busy !== 1'b1 || bus.o_read_en !== 1'b0 || bus.o_tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_rd_entry got busy=%b rd=%b txv=%b exp 1 0 0", bus.o_busy, bus.o_read_en, bus.o_tx_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    outs = {bus.o_rx_ready, bus.o_tx_valid, bus.o_tx_data, bus.o_addr, bus.o_data, bus.o_byte_we, bus.o_read_en, bus.o_busy};
    vectors++;
    if (outs !== '0) begin
      miscompares++;
      $display("FAIL async_reset_wait_rd got %h exp 0", outs);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    vectors++;
    if (tx_q.size() !== 0 || bus.o_busy !== 1'b0 || bus.o_rx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL after_reset_rd got bytes=%0d busy=%b ready=%b exp 0 0 1", tx_q.size(), bus.o_busy, bus.o_rx_ready);
    end
    ev_q.delete();
    send_cmd(8'h57, 32'h0000_0018, 32'hA5A5_5A5A, 0);
    vectors++;
    if (bus.o_byte_we !== 4'hF) begin
      miscompares++;
      $display("FAIL wr_strobe_live got %h exp f", bus.o_byte_we);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.o_byte_we !== 4'h0 || bus.o_addr !== '0 || bus.o_data !== 32'h0) begin
      miscompares++;
      $display("FAIL async_reset_strobe got we=%h addr=%h data=%h exp 0 0 0", bus.o_byte_we, bus.o_addr, bus.o_data);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    vectors++;
    if (tx_q.size() !== 0) begin
      miscompares++;
      $display("FAIL after_reset_wr got bytes=%0d exp 0", tx_q.size());
    end
  endtask

  task automatic test_exclusive_strobes();
    vectors++;
    if (conflicts !== 0) begin
      miscompares++;
      $display("FAIL strobe_overlap got %0d cycles exp 0", conflicts);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_opcode();
    test_backpressure();
    test_timeout();
    test_back_to_back();
    test_random();
    test_async_reset();
    test_exclusive_strobes();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
